// File: rtl/sprite_cmd_dispatcher.sv
// Buffers sprite commands from the Avalon-MM bridge and broadcasts one word per cycle.
// Buffer-swap (flush) words wait for vertical blanking, with at most one swap per frame.
module sprite_cmd_dispatcher #(
    parameter int         DEPTH       = 16,
    parameter logic [9:0] VBLANK_LINE = 10'd480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    input  logic [9:0]  vcount,
    output logic [31:0] writedata,
    output logic        fifo_full,
    output logic        swap_pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {ISSUE, WAIT_VB} state_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [31:0]   writedata_q, writedata_d;
    logic [31:0]   readdata_q, readdata_d;
    logic          overflow_q, overflow_d;
    logic          swapped_q, swapped_d;
    logic [7:0]    frame_swaps_q, frame_swaps_d;

    logic          wr_req, rd_req, push, pop;
    logic          in_vblank, head_flush;
    logic [31:0]   head;
    logic [4:0]    count5;

    always_comb begin
        wr_req        = chipselect & write;
        rd_req        = chipselect & read;
        in_vblank     = (vcount >= VBLANK_LINE);
        head          = mem[rd_ptr_q];
        head_flush    = (head[20:17] == 4'hF);

        pop           = 1'b0;
        writedata_d   = 32'h0;
        state_d       = state_q;
        swapped_d     = swapped_q;
        frame_swaps_d = frame_swaps_q;

        // Line 0 opens a new frame, re-arming the one-swap-per-frame allowance.
        if (vcount == 10'd0)
            swapped_d = 1'b0;

        case (state_q)
            ISSUE: begin
                if (count_q != '0) begin
                    if (!head_flush) begin
                        pop         = 1'b1;
                        writedata_d = head;
                    end else begin
                        state_d = WAIT_VB;
                    end
                end
            end
            WAIT_VB: begin
                if (in_vblank && !swapped_q) begin
                    pop           = 1'b1;
                    writedata_d   = head;
                    swapped_d     = 1'b1;
                    frame_swaps_d = frame_swaps_q + 8'd1;
                    state_d       = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase

        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        push     = wr_req && ((count_q != DEPTH_C) || pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);

        overflow_d = overflow_q;
        if (rd_req)
            overflow_d = 1'b0;
        if (wr_req && !push)
            overflow_d = 1'b1;

        count5     = 5'(count_q);
        readdata_d = readdata_q;
        if (rd_req)
            readdata_d = {overflow_q, (state_q == WAIT_VB), 6'b0, frame_swaps_q, 11'b0, count5};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= ISSUE;
            writedata_q   <= 32'h0;
            readdata_q    <= 32'h0;
            overflow_q    <= 1'b0;
            swapped_q     <= 1'b0;
            frame_swaps_q <= 8'd0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            writedata_q   <= writedata_d;
            readdata_q    <= readdata_d;
            overflow_q    <= overflow_d;
            swapped_q     <= swapped_d;
            frame_swaps_q <= frame_swaps_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push)
            mem[wr_ptr_q] <= avs_writedata;
    end

    assign writedata    = writedata_q;
    assign avs_readdata = readdata_q;
    assign fifo_full    = (count_q == DEPTH_C);
    assign swap_pending = (state_q == WAIT_VB);

endmodule
